mem_bus_controller: RTL and testbench

- Sits directly downstream of the CPU control unit's RAM port and arbitrates every load, store and instruction fetch.
- Routes requests either to external synchronous SRAM, with a parameterised number of wait states, or to a small memory-mapped I/O block.
- I/O block contents: GPIO output register, synchronised GPIO input, and a 32-bit free-running cycle counter.
- Returns read data with a one-cycle cpu_ready completion pulse.

---
 rtl/retro16_bus_pkg.sv | 18 +
 rtl/mmio_regs.sv | 73 +++++++
 rtl/mem_bus_controller.sv | 158 +++++++++++++++
 tb/tb_mem_bus_controller.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/retro16_bus_pkg.sv
// Shared definitions for the retro16 memory bus controller.
//   - MMIO register offsets (low address byte inside the I/O page)
//   - Bus FSM state encoding
package retro16_bus_pkg;

   localparam logic [7:0] IO_GPIO_OUT = 8'h00;
   localparam logic [7:0] IO_GPIO_IN  = 8'h01;
   localparam logic [7:0] IO_CYCLE_LO = 8'h02;
   localparam logic [7:0] IO_CYCLE_HI = 8'h03;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StSramAcc = 2'd1,
      StIoAcc   = 2'd2,
      StDone    = 2'd3
   } bus_state_e;

endpackage

// File: rtl/mmio_regs.sv
// Memory-mapped I/O register block for the retro16 bus.
//   clk_i       system clock
//   rst_n       asynchronous active-low reset
//   strobe_i    one-cycle access strobe
//   we_i        1 = write, 0 = read
//   offset_i    register offset (low address byte)
//   wdata_i     write data
//   gpio_in_i   asynchronous external inputs
//   rdata_o     combinational read data for the addressed register
//   gpio_out_o  GPIO output register
module mmio_regs
   import retro16_bus_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n,
   input  logic        strobe_i,
   input  logic        we_i,
   input  logic [7:0]  offset_i,
   input  logic [15:0] wdata_i,
   input  logic [15:0] gpio_in_i,
   output logic [15:0] rdata_o,
   output logic [15:0] gpio_out_o
);

   logic [15:0] gpio_out_q;
   logic [15:0] sync1_q;
   logic [15:0] sync2_q;
   logic [31:0] cycle_q;
   logic [15:0] snap_q;

   logic wr_gpio;
   logic rd_cycle_lo;

   assign wr_gpio     = strobe_i && we_i && (offset_i == IO_GPIO_OUT);
   assign rd_cycle_lo = strobe_i && !we_i && (offset_i == IO_CYCLE_LO);

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         gpio_out_q <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         cycle_q    <= '0;
         snap_q     <= '0;
      end else begin
         // Free-running; wraps naturally at 2^32.
         cycle_q <= cycle_q + 32'd1;
         sync1_q <= gpio_in_i;
         sync2_q <= sync1_q;
         if (wr_gpio) begin
            gpio_out_q <= wdata_i;
         end
         // Upper half is frozen at the moment the low half is read so a
         // LO-then-HI pair forms a coherent 32-bit value.
         if (rd_cycle_lo) begin
            snap_q <= cycle_q[31:16];
         end
      end
   end

   always_comb begin
      rdata_o = '0;
      case (offset_i)
         IO_GPIO_OUT: rdata_o = gpio_out_q;
         IO_GPIO_IN:  rdata_o = sync2_q;
         IO_CYCLE_LO: rdata_o = cycle_q[15:0];
         IO_CYCLE_HI: rdata_o = snap_q;
         default:     rdata_o = '0;
      endcase
   end

   assign gpio_out_o = gpio_out_q;

endmodule

// File: rtl/mem_bus_controller.sv
// CPU memory bus controller: accepts one load/store/fetch at a time and routes
// it to external synchronous SRAM (with WAIT_STATES extra cycles) or to the
// MMIO block when the upper address byte equals IO_PAGE.
//   clk_i           system clock
//   rst_n           asynchronous active-low reset
//   cpu_addr_i      request address
//   cpu_wdata_i     store data
//   cpu_read_en_i   read request (level)
//   cpu_write_en_i  write request (level), wins over read when both set
//   cpu_rdata_o     read data, held until the next completion
//   cpu_ready_o     one-cycle completion pulse
//   sram_addr_o     SRAM address
//   sram_wdata_o    SRAM write data
//   sram_rdata_i    SRAM read data, sampled on the final access cycle
//   sram_ce_o       SRAM chip enable
//   sram_we_o       SRAM write enable
//   gpio_in_i       asynchronous GPIO inputs
//   gpio_out_o      GPIO output register
module mem_bus_controller
   import retro16_bus_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 1,
   parameter logic [7:0]  IO_PAGE     = 8'hFF
) (
   input  logic        clk_i,
   input  logic        rst_n,
   input  logic [15:0] cpu_addr_i,
   input  logic [15:0] cpu_wdata_i,
   input  logic        cpu_read_en_i,
   input  logic        cpu_write_en_i,
   output logic [15:0] cpu_rdata_o,
   output logic        cpu_ready_o,
   output logic [15:0] sram_addr_o,
   output logic [15:0] sram_wdata_o,
   input  logic [15:0] sram_rdata_i,
   output logic        sram_ce_o,
   output logic        sram_we_o,
   input  logic [15:0] gpio_in_i,
   output logic [15:0] gpio_out_o
);

   localparam logic [3:0] WaitInit = 4'(WAIT_STATES);

   bus_state_e  state_q;
   logic        armed_q;
   logic [15:0] addr_q;
   logic [15:0] wdata_q;
   logic        is_wr_q;
   logic [3:0]  wait_q;
   logic [15:0] cpu_rdata_q;
   logic        cpu_ready_q;
   logic        sram_ce_q;
   logic        sram_we_q;

   logic        req_any;
   logic        accept;
   logic        req_is_io;
   logic        io_strobe;
   logic [15:0] io_rdata;

   assign req_any   = cpu_read_en_i | cpu_write_en_i;
   assign accept    = (state_q == StIdle) && armed_q && req_any;
   assign req_is_io = (cpu_addr_i[15:8] == IO_PAGE);
   assign io_strobe = (state_q == StIoAcc);

   mmio_regs u_mmio (
      .clk_i      (clk_i),
      .rst_n      (rst_n),
      .strobe_i   (io_strobe),
      .we_i       (is_wr_q),
      .offset_i   (addr_q[7:0]),
      .wdata_i    (wdata_q),
      .gpio_in_i  (gpio_in_i),
      .rdata_o    (io_rdata),
      .gpio_out_o (gpio_out_o)
   );

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         armed_q     <= 1'b1;
         addr_q      <= '0;
         wdata_q     <= '0;
         is_wr_q     <= 1'b0;
         wait_q      <= '0;
         cpu_rdata_q <= '0;
         cpu_ready_q <= 1'b0;
         sram_ce_q   <= 1'b0;
         sram_we_q   <= 1'b0;
      end else begin
         cpu_ready_q <= 1'b0;

         // Level-sensitive enables: a held request must fall before it can
         // issue another access.
         if (!req_any) begin
            armed_q <= 1'b1;
         end else if (accept) begin
            armed_q <= 1'b0;
         end

         case (state_q)
            StIdle: begin
               if (accept) begin
                  addr_q  <= cpu_addr_i;
                  wdata_q <= cpu_wdata_i;
                  is_wr_q <= cpu_write_en_i;
                  if (req_is_io) begin
                     state_q <= StIoAcc;
                  end else begin
                     state_q   <= StSramAcc;
                     sram_ce_q <= 1'b1;
                     sram_we_q <= cpu_write_en_i;
                     wait_q    <= WaitInit;
                  end
               end
            end

            StSramAcc: begin
               if (wait_q == 4'd0) begin
                  if (!is_wr_q) begin
                     cpu_rdata_q <= sram_rdata_i;
                  end
                  sram_ce_q   <= 1'b0;
                  sram_we_q   <= 1'b0;
                  cpu_ready_q <= 1'b1;
                  state_q     <= StDone;
               end else begin
                  wait_q <= wait_q - 4'd1;
               end
            end

            StIoAcc: begin
               if (!is_wr_q) begin
                  cpu_rdata_q <= io_rdata;
               end
               cpu_ready_q <= 1'b1;
               state_q     <= StDone;
            end

            StDone: begin
               state_q <= StIdle;
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign cpu_rdata_o  = cpu_rdata_q;
   assign cpu_ready_o  = cpu_ready_q;
   assign sram_addr_o  = addr_q;
   assign sram_wdata_o = wdata_q;
   assign sram_ce_o    = sram_ce_q;
   assign sram_we_o    = sram_we_q;

endmodule

// File: tb/tb_mem_bus_controller.sv
// Self-checking bench: two controllers (1 and 3 wait states) share the CPU-side
// stimulus; each has its own behavioural SRAM. Expectations come from a
// transaction-level model of the memory map and from elapsed simulation time.
module tb_mem_bus_controller;

   localparam int unsigned WsA = 1;
   localparam int unsigned WsB = 3;

   logic        clk_i = 1'b0;
   logic        rst_n;
   logic [15:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic        rd_en;
   logic        wr_en;
   logic [15:0] gpio_in;

   logic [15:0] a_rdata, a_saddr, a_swdata, a_srdata, a_gpio;
   logic        a_ready, a_ce, a_we;
   logic [15:0] b_rdata, b_saddr, b_swdata, b_srdata, b_gpio;
   logic        b_ready, b_ce, b_we;

   always #5 clk_i = ~clk_i;

   mem_bus_controller #(.WAIT_STATES(WsA), .IO_PAGE(8'hFF)) dut_a (
      .clk_i          (clk_i),
      .rst_n          (rst_n),
      .cpu_addr_i     (cpu_addr),
      .cpu_wdata_i    (cpu_wdata),
      .cpu_read_en_i  (rd_en),
      .cpu_write_en_i (wr_en),
      .cpu_rdata_o    (a_rdata),
      .cpu_ready_o    (a_ready),
      .sram_addr_o    (a_saddr),
      .sram_wdata_o   (a_swdata),
      .sram_rdata_i   (a_srdata),
      .sram_ce_o      (a_ce),
      .sram_we_o      (a_we),
      .gpio_in_i      (gpio_in),
      .gpio_out_o     (a_gpio)
   );

   mem_bus_controller #(.WAIT_STATES(WsB), .IO_PAGE(8'hFF)) dut_b (
      .clk_i          (clk_i),
      .rst_n          (rst_n),
      .cpu_addr_i     (cpu_addr),
      .cpu_wdata_i    (cpu_wdata),
      .cpu_read_en_i  (rd_en),
      .cpu_write_en_i (wr_en),
      .cpu_rdata_o    (b_rdata),
      .cpu_ready_o    (b_ready),
      .sram_addr_o    (b_saddr),
      .sram_wdata_o   (b_swdata),
      .sram_rdata_i   (b_srdata),
      .sram_ce_o      (b_ce),
      .sram_we_o      (b_we),
      .gpio_in_i      (gpio_in),
      .gpio_out_o     (b_gpio)
   );

   // Power-up SRAM contents; 0x0100 holds the known word used by the first read.
   function automatic logic [15:0] init_word(input logic [15:0] a);
      return (a == 16'h0100) ? 16'hBEEF : (a ^ 16'hC3A5);
   endfunction

   bit [15:0] mem_a [65536];
   bit        vld_a [65536];
   bit [15:0] mem_b [65536];
   bit        vld_b [65536];

   assign a_srdata = vld_a[a_saddr] ? mem_a[a_saddr] : init_word(a_saddr);
   assign b_srdata = vld_b[b_saddr] ? mem_b[b_saddr] : init_word(b_saddr);

   always @(posedge clk_i) begin
      if (a_ce && a_we) begin
         mem_a[a_saddr] <= a_swdata;
         vld_a[a_saddr] <= 1'b1;
      end
      if (b_ce && b_we) begin
         mem_b[b_saddr] <= b_swdata;
         vld_b[b_saddr] <= 1'b1;
      end
   end

   // Reference state
   logic [15:0] ref_mem [logic [15:0]];
   logic [15:0] ref_gpio_out;
   logic [15:0] ref_snap;
   logic [15:0] exp_rdata;
   time         t_rel;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_dut(input string nm, input int lat, input int elat, input int rdy,
                            input int ce, input int ece, input int we, input int ewe,
                            input int bad, input logic [15:0] got, input logic [15:0] gpio);
      check_eq({nm, "_latency"}, 32'(lat), 32'(elat));
      check_eq({nm, "_ready_pulses"}, 32'(rdy), 32'd1);
      check_eq({nm, "_ce_cycles"}, 32'(ce), 32'(ece));
      check_eq({nm, "_we_cycles"}, 32'(we), 32'(ewe));
      check_eq({nm, "_sram_bus"}, 32'(bad), 32'd0);
      check_eq({nm, "_rdata"}, 32'(got), 32'(exp_rdata));
      check_eq({nm, "_gpio_out"}, 32'(gpio), 32'(ref_gpio_out));
   endtask

   // Issue one request with the enables held for 'hold' cycles, then check
   // both controllers against the model.
   task automatic run_op(input logic [15:0] addr, input logic [15:0] wd, input logic rd,
                         input logic wr, input int hold);
      logic        is_io;
      logic [7:0]  off;
      logic [31:0] cyc;
      int lat_a, lat_b, rdy_a, rdy_b, ce_a, ce_b, we_a, we_b, bad_a, bad_b;
      logic [15:0] got_a, got_b;
      int elat_a, elat_b, ece_a, ece_b, ewe_a, ewe_b;

      is_io = (addr[15:8] == 8'hFF);
      off   = addr[7:0];
      // Counter value during the cycle after acceptance (the I/O access cycle).
      cyc   = 32'(($time - t_rel) / 10) + 32'd1;

      if (is_io) begin
         if (wr) begin
            if (off == 8'h00) ref_gpio_out = wd;
         end else begin
            case (off)
               8'h00:   exp_rdata = ref_gpio_out;
               8'h01:   exp_rdata = gpio_in;
               8'h02: begin
                  exp_rdata = cyc[15:0];
                  ref_snap  = cyc[31:16];
               end
               8'h03:   exp_rdata = ref_snap;
               default: exp_rdata = 16'h0000;
            endcase
         end
      end else if (wr) begin
         ref_mem[addr] = wd;
      end else begin
         exp_rdata = ref_mem.exists(addr) ? ref_mem[addr] : init_word(addr);
      end

      elat_a = is_io ? 2 : int'(WsA) + 2;
      elat_b = is_io ? 2 : int'(WsB) + 2;
      ece_a  = is_io ? 0 : int'(WsA) + 1;
      ece_b  = is_io ? 0 : int'(WsB) + 1;
      ewe_a  = (!is_io && wr) ? ece_a : 0;
      ewe_b  = (!is_io && wr) ? ece_b : 0;

      lat_a = -1; lat_b = -1; rdy_a = 0; rdy_b = 0; ce_a = 0; ce_b = 0;
      we_a = 0; we_b = 0; bad_a = 0; bad_b = 0; got_a = '0; got_b = '0;

      cpu_addr  = addr;
      cpu_wdata = wd;
      rd_en     = rd;
      wr_en     = wr;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk_i);
         if (a_ready) begin
            rdy_a++;
            if (lat_a < 0) begin
               lat_a = k;
               got_a = a_rdata;
            end
         end
         if (b_ready) begin
            rdy_b++;
            if (lat_b < 0) begin
               lat_b = k;
               got_b = b_rdata;
            end
         end
         if (a_ce) ce_a++;
         if (b_ce) ce_b++;
         if (a_ce && a_we) we_a++;
         if (b_ce && b_we) we_b++;
         if (a_ce && (a_saddr != addr || (wr && a_swdata != wd))) bad_a++;
         if (b_ce && (b_saddr != addr || (wr && b_swdata != wd))) bad_b++;
         if (k == hold) begin
            rd_en = 1'b0;
            wr_en = 1'b0;
         end
         if (k >= hold && lat_a > 0 && lat_b > 0) break;
      end
      rd_en = 1'b0;
      wr_en = 1'b0;

      check_dut("a", lat_a, elat_a, rdy_a, ce_a, ece_a, we_a, ewe_a, bad_a, got_a, a_gpio);
      check_dut("b", lat_b, elat_b, rdy_b, ce_b, ece_b, we_b, ewe_b, bad_b, got_b, b_gpio);

      // One idle cycle re-arms, then give the synchroniser time to settle.
      @(negedge clk_i);
      gpio_in = 16'($urandom);
      repeat (2) @(negedge clk_i);
   endtask

   initial begin
      int quiet_rdy;
      logic [15:0] rwd;

      rst_n        = 1'b0;
      cpu_addr     = '0;
      cpu_wdata    = '0;
      rd_en        = 1'b0;
      wr_en        = 1'b0;
      gpio_in      = 16'h5A3C;
      ref_gpio_out = '0;
      ref_snap     = '0;
      exp_rdata    = '0;
      t_rel        = 0;

      repeat (2) @(negedge clk_i);
      check_eq("rst_a_ready", 32'(a_ready), 32'd0);
      check_eq("rst_a_ce", 32'(a_ce), 32'd0);
      check_eq("rst_a_we", 32'(a_we), 32'd0);
      check_eq("rst_a_rdata", 32'(a_rdata), 32'd0);
      check_eq("rst_a_saddr", 32'(a_saddr), 32'd0);
      check_eq("rst_a_swdata", 32'(a_swdata), 32'd0);
      check_eq("rst_a_gpio", 32'(a_gpio), 32'd0);
      check_eq("rst_b_ce", 32'(b_ce), 32'd0);
      check_eq("rst_b_rdata", 32'(b_rdata), 32'd0);
      rst_n = 1'b1;
      t_rel = $time;

      // Directed sequence
      run_op(16'h0100, 16'h0000, 1'b1, 1'b0, 1);
      run_op(16'h0200, 16'h1234, 1'b0, 1'b1, 6);
      run_op(16'h0200, 16'h0000, 1'b1, 1'b0, 1);
      run_op(16'hFF00, 16'h00A5, 1'b0, 1'b1, 1);
      run_op(16'hFF00, 16'h0000, 1'b1, 1'b0, 2);
      run_op(16'hFF01, 16'h0000, 1'b1, 1'b0, 1);
      run_op(16'hFF01, 16'hFFFF, 1'b0, 1'b1, 1);
      run_op(16'hFF00, 16'h0000, 1'b1, 1'b0, 1);

      // Randomised traffic over a small SRAM window and the I/O page
      for (int i = 0; i < 40; i++) begin
         logic [15:0] ad;
         logic        r;
         logic        w;
         if ($urandom_range(0, 1) == 0) begin
            ad = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 7))};
         end else begin
            ad = {8'hFF, 8'($urandom_range(0, 5))};
         end
         w = 1'($urandom_range(0, 1));
         r = w ? 1'($urandom_range(0, 1)) : 1'b1;
         run_op(ad, 16'($urandom), r, w, int'($urandom_range(1, 5)));
      end

      // Read CYCLE_LO just before bit 16 carries, then CYCLE_HI after the carry:
      // HI must come from the snapshot, not the live counter.
      while ((32'(($time - t_rel) / 10) % 32'd65536) != 32'd65534) @(negedge clk_i);
      run_op(16'hFF02, 16'h0000, 1'b1, 1'b0, 1);
      repeat (10) @(negedge clk_i);
      run_op(16'hFF03, 16'h0000, 1'b1, 1'b0, 1);

      // Reset during the second SRAM cycle of a both-enables request
      rwd       = 16'($urandom);
      cpu_addr  = 16'h0300;
      cpu_wdata = rwd;
      rd_en     = 1'b1;
      wr_en     = 1'b1;
      repeat (2) @(negedge clk_i);
      check_eq("abort_pre_b_we", 32'(b_ce && b_we), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("abort_a_ce", 32'(a_ce), 32'd0);
      check_eq("abort_a_we", 32'(a_we), 32'd0);
      check_eq("abort_a_ready", 32'(a_ready), 32'd0);
      check_eq("abort_b_ce", 32'(b_ce), 32'd0);
      check_eq("abort_b_we", 32'(b_we), 32'd0);
      check_eq("abort_b_ready", 32'(b_ready), 32'd0);
      rd_en = 1'b0;
      wr_en = 1'b0;
      ref_mem[16'h0300] = rwd;
      ref_gpio_out = '0;
      ref_snap     = '0;
      exp_rdata    = '0;
      @(negedge clk_i);
      rst_n = 1'b1;
      t_rel = $time;
      quiet_rdy = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk_i);
         if (a_ready || b_ready) quiet_rdy++;
      end
      check_eq("abort_no_ready", 32'(quiet_rdy), 32'd0);
      check_eq("abort_a_rdata", 32'(a_rdata), 32'd0);
      check_eq("abort_b_gpio", 32'(b_gpio), 32'd0);
      run_op(16'hFF07, 16'h0000, 1'b1, 1'b0, 1);
      run_op(16'h0300, 16'h0000, 1'b1, 1'b0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
